// File: rtl/sc_fir_pkg.sv
// rtl/sc_fir_pkg.sv - shared state enum and default sizes for the stochastic FIR sequencer
package sc_fir_pkg;

  localparam int SC_N       = 12;
  localparam int SC_LENGTH  = 19;
  localparam int SC_LEN_IDX = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sc_vdc_cnt.sv
// rtl/sc_vdc_cnt.sv - window counter with forward and bit-reversed (van der Corput) outputs
module sc_vdc_cnt
  import sc_fir_pkg::*;
#(
  parameter int N = SC_N
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [N-1:0] o_cnt,
  output logic [N-1:0] o_cnt_rev
);

  logic [N-1:0] r_cnt;
  logic [N-1:0] w_rev;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_rev = '0;
    for (int i = 0; i < N; i++) begin
      w_rev[i] = r_cnt[N-1-i];
    end
  end

  assign o_cnt     = r_cnt;
  assign o_cnt_rev = w_rev;

endmodule

// File: rtl/sc_fir_seq.sv
// rtl/sc_fir_seq.sv - stochastic FIR window sequencer; optional abort input under SC_FIR_SEQ_ABORT_EN
module sc_fir_seq
  import sc_fir_pkg::*;
#(
  parameter int N       = SC_N,
  parameter int LENGTH  = SC_LENGTH,
  parameter int LEN_IDX = SC_LEN_IDX
) (
  input  logic               clock,
  input  logic               reset_n,
`ifdef SC_FIR_SEQ_ABORT_EN
  input  logic               abort,
`endif
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N-1:0]       in_sample,
  output logic [N-1:0]       rng_re,
  output logic [LEN_IDX-1:0] tap_sel,
  output logic [N-1:0]       tap_sample,
  output logic               run,
  input  logic               sc_bit,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N:0]         out_count
);

  localparam logic [LEN_IDX-1:0] TAP_LAST = LEN_IDX'(LENGTH - 1);

  state_t             r_state;
  state_t             w_next;
  logic [N-1:0]       r_d [0:LENGTH-1];
  logic [LEN_IDX-1:0] r_tap;
  logic [N:0]         r_acc;
  logic [N:0]         r_out_count;
  logic [N-1:0]       w_cnt;
  logic [N-1:0]       w_cnt_rev;
  logic               w_accept;
  logic               w_last;
  logic               w_abort;
  logic               w_run;

  assign w_run    = (r_state == RUN);
  assign w_accept = (r_state == IDLE) && in_valid;
  assign w_last   = w_run && (w_cnt == '1);

`ifdef SC_FIR_SEQ_ABORT_EN
  assign w_abort = abort && (r_state != IDLE);
`else
  assign w_abort = 1'b0;
`endif

  sc_vdc_cnt #(.N(N)) u_cnt (
    .clock     (clock),
    .reset_n   (reset_n),
    .i_clr     (w_accept),
    .i_en      (w_run),
    .o_cnt     (w_cnt),
    .o_cnt_rev (w_cnt_rev)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (w_abort) w_next = IDLE;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Abort leaves the delay line untouched; only an accepted sample shifts it.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int k = 0; k < LENGTH; k++) r_d[k] <= '0;
    end else if (w_accept) begin
      r_d[0] <= in_sample;
      for (int k = 1; k < LENGTH; k++) r_d[k] <= r_d[k-1];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_tap <= '0;
      r_acc <= '0;
    end else if (w_accept || w_abort) begin
      r_tap <= '0;
      r_acc <= '0;
    end else if (w_run) begin
      r_tap <= (r_tap == TAP_LAST) ? '0 : r_tap + 1'b1;
      r_acc <= r_acc + (N+1)'(sc_bit);
    end
  end

  // The last bit of the window is folded in here rather than waiting a cycle for r_acc.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_out_count <= '0;
    end else if (w_last && !w_abort) begin
      r_out_count <= r_acc + (N+1)'(sc_bit);
    end
  end

  assign in_ready   = (r_state == IDLE);
  assign run        = w_run;
  assign out_valid  = (r_state == DONE);
  assign out_count  = r_out_count;
  assign rng_re     = w_run ? w_cnt_rev : '0;
  assign tap_sel    = w_run ? r_tap : '0;
  assign tap_sample = r_d[tap_sel];

endmodule

// File: tb/tb_sc_fir_seq.sv
// tb/tb_sc_fir_seq.sv - randomized scoreboard bench for sc_fir_seq (N=4, LENGTH=3)
module tb_sc_fir_seq;

  localparam int N  = 4;
  localparam int L  = 3;
  localparam int LI = 2;
  localparam int W  = 1 << N;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  in_sample = '0;
  logic [N-1:0]  rng_re;
  logic [LI-1:0] tap_sel;
  logic [N-1:0]  tap_sample;
  logic          run;
  logic          sc_bit = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [N:0]    out_count;

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];
  int dl[L];

  always #5 clock = ~clock;

  sc_fir_seq #(.N(N), .LENGTH(L), .LEN_IDX(LI)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sample  (in_sample),
    .rng_re     (rng_re),
    .tap_sel    (tap_sel),
    .tap_sample (tap_sample),
    .run        (run),
    .sc_bit     (sc_bit),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_count  (out_count)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rev_bits(input int v);
    int r = 0;
    for (int b = 0; b < N; b++)
      if (((v >> b) & 1) != 0) r += 1 << (N - 1 - b);
    return r;
  endfunction

  // Scoreboard monitor: every completed result handshake pops one expectation.
  initial begin
    forever begin
      @(negedge clock);
      #2;
      if (reset_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_out_valid", int'(out_valid), 0);
        else                   check("out_count", int'(out_count), exp_q.pop_front());
      end
    end
  end

  // mode: 0 all ones, 1 sc_bit = cycle index lsb, 2 all zeros, 3 random
  task automatic window(input int sample, input int mode, input int hold, input int rst_at);
    int bits[W];
    int sum = 0;
    int waited = 0;
    for (int i = 0; i < W; i++) begin
      case (mode)
        0:       bits[i] = 1;
        1:       bits[i] = i & 1;
        2:       bits[i] = 0;
        default: bits[i] = int'($urandom_range(0, 1));
      endcase
      sum += bits[i];
    end

    while (!in_ready && waited < 50) begin
      @(negedge clock);
      waited++;
    end
    check("in_ready_idle", int'(in_ready), 1);
    check("idle_tap_sample", int'(tap_sample), dl[0]);
    check("idle_run", int'(run), 0);
    in_valid  = 1'b1;
    in_sample = N'(sample);
    @(negedge clock);
    for (int k = L - 1; k > 0; k--) dl[k] = dl[k-1];
    dl[0] = sample;

    for (int i = 0; i < W; i++) begin
      if (i == rst_at) begin
        reset_n  = 1'b0;
        in_valid = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        for (int k = 0; k < L; k++) dl[k] = 0;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_run", int'(run), 0);
        check("rst_out_count", int'(out_count), 0);
        check("rst_tap_sample", int'(tap_sample), 0);
        out_ready = 1'b1;
        for (int c = 0; c < W + 4; c++) begin
          check("rst_no_out_valid", int'(out_valid), 0);
          @(negedge clock);
        end
        out_ready = 1'b0;
        return;
      end
      check("run_high", int'(run), 1);
      check("rng_re", int'(rng_re), rev_bits(i));
      check("tap_sel", int'(tap_sel), i % L);
      check("tap_sample", int'(tap_sample), dl[i % L]);
      check("run_in_ready", int'(in_ready), 0);
      check("run_out_valid", int'(out_valid), 0);
      sc_bit    = bits[i][0];
      in_valid  = 1'($urandom_range(0, 1));
      in_sample = N'($urandom_range(0, W - 1));
      @(negedge clock);
    end

    exp_q.push_back(sum);
    check("done_out_valid", int'(out_valid), 1);
    check("done_run", int'(run), 0);
    check("done_rng_re", int'(rng_re), 0);
    check("done_tap_sel", int'(tap_sel), 0);
    check("done_tap_sample", int'(tap_sample), dl[0]);
    for (int h = 0; h < hold; h++) begin
      in_valid  = 1'b1;
      in_sample = N'($urandom_range(0, W - 1));
      check("hold_in_ready", int'(in_ready), 0);
      check("hold_out_valid", int'(out_valid), 1);
      check("hold_out_count", int'(out_count), sum);
      @(negedge clock);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clock);
    out_ready = 1'b0;
    check("post_in_ready", int'(in_ready), 1);
    check("post_out_valid", int'(out_valid), 0);
  endtask

  initial begin
    for (int k = 0; k < L; k++) dl[k] = 0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    check("reset_in_ready", int'(in_ready), 1);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_run", int'(run), 0);
    check("reset_out_count", int'(out_count), 0);
    check("reset_rng_re", int'(rng_re), 0);
    check("reset_tap_sel", int'(tap_sel), 0);
    check("reset_tap_sample", int'(tap_sample), 0);

    window(5, 0, 0, -1);
    window(9, 1, 2, -1);
    window(1, 3, 0, -1);
    window(2, 3, 1, -1);
    window(3, 3, 0, -1);
    window(4, 1, 5, -1);
    window(7, 2, 0, -1);
    window(11, 3, 0, 7);
    window(6, 0, 0, -1);
    for (int r = 0; r < 4; r++)
      window(int'($urandom_range(0, W - 1)), 3, int'($urandom_range(0, 3)), -1);

    repeat (5) @(negedge clock);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
